mem_dp_pipe: RTL and testbench
==============================

// Module: mem_dp_pipe
// PURPOSE
//  Parametrised dual-port synchronous RAM with byte enables and a configurable read pipeline.
//  Successor to the fixed 32-bit/1-cycle test memory. Sits behind VProc/bus decode in test benches.
//  Read data arrives with an explicit rvalid strobe, so decode logic derives read acks directly.
//  Defined same-address collision policy; optional collision detection.
// PARAMETERS
//  DATA_WIDTH  32  data bits per port; multiple of 8; BE width = DATA_WIDTH/8
//  LOG2WORDS   14  address bits; depth = 2**LOG2WORDS words
//  RD_LATENCY  1   cycles from accepted read to rvalid; legal range 1..4
// PORTS
//  clk         in   1             rising-edge clock
//  nreset      in   1             asynchronous active-low reset
//  cs0/cs1     in   1             port select; a request is accepted on any clk edge with cs high
//  we0/we1     in   1             1 = write, 0 = read (qualified by cs)
//  be0/be1     in   DATA_WIDTH/8  byte enables, writes only
//  a0/a1       in   LOG2WORDS     word address
//  di0/di1     in   DATA_WIDTH    write data
//  do0/do1     out  DATA_WIDTH    read data, valid when rv0/rv1 high
//  rv0/rv1     out  1             read-valid strobe, one cycle per accepted read
//  col_err     out  1             collision flag (MEM_COLLISION_DET_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (nreset low, async): do0/do1 = 0; rv0/rv1 = 0; col_err = 0; all pipeline valid bits cleared.
//    Array contents are not reset.
//  - Throughput: each port accepts one request per cycle, fully pipelined, no back-pressure.
//  - Write (cs & we): at the edge, each byte i with be[i] = 1 is updated from di; other bytes kept.
//    No rv pulse. A write with be = 0 is a no-op.
//  - Read (cs & ~we): array sampled at the accepting edge, then delayed through RD_LATENCY-1
//    register stages. rv and do assert together exactly RD_LATENCY cycles after acceptance.
//  - do holds its last valid value while rv = 0 (never X after the first read).
//  - Read vs write, same address, same edge:
//    - Read-first: returns pre-write data.
//    - Applies same-port (impossible, we exclusive) and cross-port.
//  - Write/write, same address, same edge: port 1 wins on every byte both ports enable.
//    Bytes enabled by only one port take that port's data.
//  - Pipelines for port 0 and port 1 are independent; no ordering between ports.
//  - Reset mid-operation: in-flight reads are discarded (no rv after reset release).
//    First accepted request after release behaves normally.
//  - Address is always in range (power-of-two depth); no wrap logic required.
//  - RD_LATENCY outside 1..4: elaboration error via generate-time check.
// CONFIGURATION
//  MEM_COLLISION_DET_EN defined:
//    - col_err registered high for one cycle after any edge where cs0 & cs1 & a0 == a1
//      and at least one port writes.
//    - Write/write collisions additionally print $display warning with address.
//    - Data behaviour is unchanged.
//  MEM_COLLISION_DET_EN undefined: col_err constant 0; no detection logic or messages.
// TESTING
//  1. Reset: nreset low mid-read with RD_LATENCY=3 -> do0/do1 = 0, rv = 0; no rv pulse after release.
//  2. Latency: write 32'hdeadbeef @0x10 via port1, read port0 -> rv0 high RD_LATENCY cycles later,
//     do0 = 32'hdeadbeef; sweep RD_LATENCY 1..4.
//  3. Byte enables: write 32'h11223344 be=4'hf, then 32'haabbccdd be=4'b0101 -> read = 32'h11bb33dd.
//  4. Back-to-back: port0 reads 0..7 on consecutive cycles -> 8 contiguous rv0 pulses, data in order.
//  5. Collision: port0 writes 32'h0 be=f, port1 writes 32'hffff0000 be=4'b1100, same addr/edge
//     -> read = 32'hffff0000; col_err pulses once only when MEM_COLLISION_DET_EN is defined.
//  6. Read-first: port0 reads addr 5 (old 32'h1) while port1 writes 32'h2 there
//     -> do0 = 32'h1; next read returns 32'h2.

Source files
------------

// File: rtl/mem_dp_pipe.sv
// Dual-port synchronous RAM with byte enables, read-first collisions and a RD_LATENCY-deep read pipeline.
// Optional collision flag and write/write warning are enabled by defining MEM_COLLISION_DET_EN.
module mem_dp_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG2WORDS  = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    nreset_i,
    input  logic                    cs0_i,
    input  logic                    we0_i,
    input  logic [DATA_WIDTH/8-1:0] be0_i,
    input  logic [LOG2WORDS-1:0]    a0_i,
    input  logic [DATA_WIDTH-1:0]   di0_i,
    input  logic                    cs1_i,
    input  logic                    we1_i,
    input  logic [DATA_WIDTH/8-1:0] be1_i,
    input  logic [LOG2WORDS-1:0]    a1_i,
    input  logic [DATA_WIDTH-1:0]   di1_i,
    output logic [DATA_WIDTH-1:0]   do0_o,
    output logic                    rv0_o,
    output logic [DATA_WIDTH-1:0]   do1_o,
    output logic                    rv1_o,
    output logic                    col_err_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** LOG2WORDS;

    generate
        if (RD_LATENCY < 1 || RD_LATENCY > 4 || (DATA_WIDTH % 8) != 0) begin : g_bad_param
            $error("mem_dp_pipe: RD_LATENCY must be 1..4 and DATA_WIDTH a multiple of 8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr0, wr1;
    logic [1:0]            rd;
    logic [LOG2WORDS-1:0]  addr [2];

    assign wr0     = cs0_i & we0_i;
    assign wr1     = cs1_i & we1_i;
    assign rd[0]   = cs0_i & ~we0_i;
    assign rd[1]   = cs1_i & ~we1_i;
    assign addr[0] = a0_i;
    assign addr[1] = a1_i;

    // Port 1 is applied second so it wins on bytes both ports enable at the same address.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (wr0 && be0_i[i]) mem_q[a0_i][8*i +: 8] <= di0_i[8*i +: 8];
            if (wr1 && be1_i[i]) mem_q[a1_i][8*i +: 8] <= di1_i[8*i +: 8];
        end
    end

    logic [DATA_WIDTH-1:0] dat_q [2][RD_LATENCY];
    logic [DATA_WIDTH-1:0] dat_d [2][RD_LATENCY];
    logic [RD_LATENCY-1:0] vld_q [2];
    logic [RD_LATENCY-1:0] vld_d [2];

    // Stage 0 samples the array before this edge's writes land (read-first); stages only load
    // when fed valid data so the output holds its last read value.
    always_comb begin
        dat_d = dat_q;
        for (int p = 0; p < 2; p++) begin
            vld_d[p]    = '0;
            vld_d[p][0] = rd[p];
            if (rd[p]) dat_d[p][0] = mem_q[addr[p]];
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_d[p][k] = vld_q[p][k-1];
                if (vld_q[p][k-1]) dat_d[p][k] = dat_q[p][k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
                for (int k = 0; k < RD_LATENCY; k++) dat_q[p][k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign do0_o = dat_q[0][RD_LATENCY-1];
    assign rv0_o = vld_q[0][RD_LATENCY-1];
    assign do1_o = dat_q[1][RD_LATENCY-1];
    assign rv1_o = vld_q[1][RD_LATENCY-1];

`ifdef MEM_COLLISION_DET_EN
    logic col_d, col_q;

    assign col_d = cs0_i & cs1_i & (a0_i == a1_i) & (we0_i | we1_i);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) col_q <= 1'b0;
        else           col_q <= col_d;
    end

    assign col_err_o = col_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (nreset_i && wr0 && wr1 && (a0_i == a1_i))
            $display("mem_dp_pipe: write/write collision at address 0x%0h", a0_i);
    end
`endif
`else
    assign col_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_dp_pipe.sv
// Directed bench for mem_dp_pipe: four instances (RD_LATENCY 1..4) share stimulus, each checked
// against hand-computed data and its own rv timing.
module tb_mem_dp_pipe;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NL = 4;
`ifdef MEM_COLLISION_DET_EN
    localparam logic COL_EN = 1'b1;
`else
    localparam logic COL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset;
    logic          cs0, we0, cs1, we1;
    logic [3:0]    be0, be1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] di0, di1;

    logic [DW-1:0] do0_w [NL];
    logic [DW-1:0] do1_w [NL];
    logic          rv0_w [NL];
    logic          rv1_w [NL];
    logic          col_w [NL];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_dp_pipe #(.DATA_WIDTH(DW), .LOG2WORDS(AW), .RD_LATENCY(g + 1)) u_dut (
            .clk_i    (clk),
            .nreset_i (nreset),
            .cs0_i    (cs0),
            .we0_i    (we0),
            .be0_i    (be0),
            .a0_i     (a0),
            .di0_i    (di0),
            .cs1_i    (cs1),
            .we1_i    (we1),
            .be1_i    (be1),
            .a1_i     (a1),
            .di1_i    (di1),
            .do0_o    (do0_w[g]),
            .rv0_o    (rv0_w[g]),
            .do1_o    (do1_w[g]),
            .rv1_o    (rv1_w[g]),
            .col_err_o(col_w[g])
        );
    end

    typedef struct {
        logic          cs0, we0;
        logic [3:0]    be0;
        logic [AW-1:0] a0;
        logic [DW-1:0] di0;
        logic          cs1, we1;
        logic [3:0]    be1;
        logic [AW-1:0] a1;
        logic [DW-1:0] di1;
        logic [DW-1:0] exp0, exp1;
        logic          col;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic c0, input logic w0, input logic [3:0] b0,
                                input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                                input logic c1, input logic w1, input logic [3:0] b1,
                                input logic [AW-1:0] ad1, input logic [DW-1:0] d1,
                                input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                input logic col);
        vec_t v;
        v.cs0 = c0; v.we0 = w0; v.be0 = b0; v.a0 = ad0; v.di0 = d0;
        v.cs1 = c1; v.we1 = w1; v.be1 = b1; v.a1 = ad1; v.di1 = d1;
        v.exp0 = e0; v.exp1 = e1; v.col = col;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        cs0 = 1'b0; we0 = 1'b0; be0 = '0; a0 = '0; di0 = '0;
        cs1 = 1'b0; we1 = 1'b0; be1 = '0; a1 = '0; di1 = '0;
    endtask

    task automatic check_zero(input string tag);
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s do0 L%0d", tag, l + 1), do0_w[l], '0);
            chk($sformatf("%s do1 L%0d", tag, l + 1), do1_w[l], '0);
            chk($sformatf("%s rv0 L%0d", tag, l + 1), {31'b0, rv0_w[l]}, '0);
            chk($sformatf("%s rv1 L%0d", tag, l + 1), {31'b0, rv1_w[l]}, '0);
            chk($sformatf("%s col L%0d", tag, l + 1), {31'b0, col_w[l]}, '0);
        end
    endtask

    // One request cycle, then five idle cycles watching every instance's rv/do/col_err.
    task automatic run_vec(input vec_t v, input int idx);
        logic rd0, rd1, erv0, erv1, ecol;
        rd0 = v.cs0 & ~v.we0;
        rd1 = v.cs1 & ~v.we1;
        @(negedge clk);
        cs0 = v.cs0; we0 = v.we0; be0 = v.be0; a0 = v.a0; di0 = v.di0;
        cs1 = v.cs1; we1 = v.we1; be1 = v.be1; a1 = v.a1; di1 = v.di1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) idle();
            ecol = COL_EN & v.col & (c == 1);
            for (int l = 0; l < NL; l++) begin
                erv0 = rd0 & (c == l + 1);
                erv1 = rd1 & (c == l + 1);
                chk($sformatf("v%0d c%0d col L%0d", idx, c, l + 1), {31'b0, col_w[l]}, {31'b0, ecol});
                chk($sformatf("v%0d c%0d rv0 L%0d", idx, c, l + 1), {31'b0, rv0_w[l]}, {31'b0, erv0});
                chk($sformatf("v%0d c%0d rv1 L%0d", idx, c, l + 1), {31'b0, rv1_w[l]}, {31'b0, erv1});
                if (erv0) chk($sformatf("v%0d do0 L%0d", idx, l + 1), do0_w[l], v.exp0);
                if (erv1) chk($sformatf("v%0d do1 L%0d", idx, l + 1), do1_w[l], v.exp1);
            end
        end
    endtask

    initial begin
        nreset = 1'b0;
        idle();
        tbl[0]  = mk(0,0,4'h0,6'h10,32'h0,        1,1,4'hf,6'h10,32'hdeadbeef, 32'h0,        32'h0,        0);
        tbl[1]  = mk(1,0,4'h0,6'h10,32'h0,        0,0,4'h0,6'h00,32'h0,        32'hdeadbeef, 32'h0,        0);
        tbl[2]  = mk(1,1,4'hf,6'h20,32'h11223344, 0,0,4'h0,6'h00,32'h0,        32'h0,        32'h0,        0);
        tbl[3]  = mk(1,1,4'h5,6'h20,32'haabbccdd, 0,0,4'h0,6'h00,32'h0,        32'h0,        32'h0,        0);
        tbl[4]  = mk(0,0,4'h0,6'h00,32'h0,        1,0,4'h0,6'h20,32'h0,        32'h0,        32'h11bb33dd, 0);
        tbl[5]  = mk(1,1,4'hf,6'h30,32'h0,        1,1,4'hc,6'h30,32'hffff0000, 32'h0,        32'h0,        1);
        tbl[6]  = mk(1,0,4'h0,6'h30,32'h0,        0,0,4'h0,6'h00,32'h0,        32'hffff0000, 32'h0,        0);
        tbl[7]  = mk(1,1,4'hf,6'h05,32'h1,        0,0,4'h0,6'h00,32'h0,        32'h0,        32'h0,        0);
        tbl[8]  = mk(1,0,4'h0,6'h05,32'h0,        1,1,4'hf,6'h05,32'h2,        32'h1,        32'h0,        1);
        tbl[9]  = mk(1,0,4'h0,6'h05,32'h0,        0,0,4'h0,6'h00,32'h0,        32'h2,        32'h0,        0);
        tbl[10] = mk(0,0,4'h0,6'h00,32'h0,        1,1,4'h0,6'h10,32'h0,        32'h0,        32'h0,        0);
        tbl[11] = mk(1,0,4'h0,6'h10,32'h0,        1,0,4'h0,6'h20,32'h0,        32'hdeadbeef, 32'h11bb33dd, 0);
        tbl[12] = mk(1,0,4'h0,6'h20,32'h0,        1,0,4'h0,6'h20,32'h0,        32'h11bb33dd, 32'h11bb33dd, 0);
        tbl[13] = mk(1,1,4'hf,6'h31,32'haaaaaaaa, 0,0,4'h0,6'h00,32'h0,        32'h0,        32'h0,        0);
        tbl[14] = mk(1,1,4'h3,6'h31,32'h12345678, 1,1,4'h6,6'h31,32'h9abcdef0, 32'h0,        32'h0,        1);
        tbl[15] = mk(0,0,4'h0,6'h00,32'h0,        1,0,4'h0,6'h31,32'h0,        32'h0,        32'haabcde78, 0);
        tbl[16] = mk(1,1,4'hf,6'h31,32'hffffffff, 1,0,4'h0,6'h31,32'h0,        32'h0,        32'haabcde78, 1);
        tbl[17] = mk(0,0,4'h0,6'h00,32'h0,        1,0,4'h0,6'h31,32'h0,        32'h0,        32'hffffffff, 0);

        repeat (2) @(negedge clk);
        check_zero("reset");
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

        // Fill words 0..7 through port 1, then stream eight back-to-back reads on port 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs1 = 1'b1; we1 = 1'b1; be1 = 4'hf; a1 = AW'(i); di1 = 32'hc0de0000 + i;
        end
        @(negedge clk);
        idle();
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) begin
                for (int l = 0; l < NL; l++) begin
                    int  k;
                    logic erv;
                    k   = c - (l + 1);
                    erv = (k >= 0) && (k < 8);
                    chk($sformatf("b2b c%0d rv0 L%0d", c, l + 1), {31'b0, rv0_w[l]}, {31'b0, erv});
                    if (erv) chk($sformatf("b2b c%0d do0 L%0d", c, l + 1), do0_w[l], 32'hc0de0000 + k);
                end
            end
            if (c < 8) begin
                cs0 = 1'b1; we0 = 1'b0; a0 = AW'(c);
            end else begin
                idle();
            end
            @(negedge clk);
        end
        for (int l = 0; l < NL; l++)
            chk($sformatf("hold do0 L%0d", l + 1), do0_w[l], 32'hc0de0007);

        // Reset lands while the read is still in flight for the deeper pipelines.
        @(negedge clk);
        cs0 = 1'b1; we0 = 1'b0; a0 = 6'h10;
        cs1 = 1'b1; we1 = 1'b0; a1 = 6'h20;
        @(posedge clk);
        @(negedge clk);
        idle();
        #2 nreset = 1'b0;
        #1 check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                chk($sformatf("postrst c%0d rv0 L%0d", c, l + 1), {31'b0, rv0_w[l]}, '0);
                chk($sformatf("postrst c%0d rv1 L%0d", c, l + 1), {31'b0, rv1_w[l]}, '0);
            end
        end
        run_vec(tbl[11], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
